gray_code_counter: RTL and testbench
====================================

// Module: gray_code_counter
//
// PURPOSE
// - Registered up/down counter with WIDTH bits that produces Gray-coded counts.
// - Intended as the source stage that feeds the Gray-to-Binary converter, e.g. as an async-FIFO read/write pointer.
// - Also exports the matching binary count, so downstream stages can cross-check the conversion.
// - Supports synchronous load of a Gray-coded start value, which is decoded internally to binary.
//
// PARAMETERS
// - WIDTH  16  Counter width in bits, for both the Gray and the binary views (WIDTH >= 2).
//
// PORTS
// - Clock_In            input   1      Rising-edge clock.
// - Reset_In            input   1      Asynchronous reset, active-high.
// - Enable_In           input   1      1 = advance the count one step on this edge.
// - Up_Down_In          input   1      Count direction: 1 = up (+1), 0 = down (-1).
// - Load_In             input   1      1 = load Load_Gray_Data_In on this edge.
// - Load_Gray_Data_In   input   WIDTH  Gray-coded value to load.
// - Gray_Count_Out      output  WIDTH  Registered Gray count.
// - Binary_Count_Out    output  WIDTH  Registered binary count, equal to the Gray-to-Binary decode of Gray_Count_Out.
// - Terminal_Count_Out  output  1      Combinational flag: the next enabled step wraps.
//
// BEHAVIOUR
// - Reset:
//   - Reset_In=1 clears Gray_Count_Out and Binary_Count_Out to 0 immediately, without waiting for a clock edge.
//   - A count step or load in progress is abandoned.
//   - Terminal_Count_Out follows from the cleared state: it is 1 only if Enable_In=1, Load_In=0 and Up_Down_In=0.
//   - Reset release: the first rising edge after Reset_In falls is a normal operating edge.
// - State: a single binary register B[WIDTH-1:0] is the internal state.
//   - Binary_Count_Out = B.
//   - Gray_Count_Out is a separate register loaded with next_B ^ (next_B >> 1) on the same edge as B.
//   - The two outputs are therefore always mutually consistent and glitch-free.
// - Per-edge priority:
//   1. Load_In=1: B <= gray2bin(Load_Gray_Data_In), Gray_Count_Out <= Load_Gray_Data_In. This overrides Enable_In and Up_Down_In.
//   2. Load_In=0 and Enable_In=1: B <= B+1 if Up_Down_In=1, otherwise B-1.
//   3. Otherwise: hold.
// - gray2bin: b[WIDTH-1] = g[WIDTH-1]; b[i] = g[i] ^ b[i+1] for i = WIDTH-2 down to 0.
// - Latency: outputs change 1 clock after the qualifying inputs are sampled. There is no pipeline beyond that register.
// - Wrap-around, modulo 2^WIDTH:
//   - Up from all-ones gives 0 (Gray 100..0 -> 000..0).
//   - Down from 0 gives all-ones (Gray 000..0 -> 100..0).
// - Single-bit property: every enabled, non-load step, including the wrap steps, changes exactly one bit of Gray_Count_Out.
// - Loads may change any number of Gray bits.
// - Terminal_Count_Out = Enable_In & ~Load_In & ((Up_Down_In & (B == all-ones)) | (~Up_Down_In & (B == 0))).
// - Direction change: Up_Down_In may toggle on any cycle. Each edge uses only the value sampled at that edge.
// - X handling: while Reset_In=0, inputs are assumed driven. Outputs never go Z.
//
// TESTING (WIDTH=16; check both outputs after every edge; count pass/fail; log to a transcript)
// 1. Reset, Enable=1, Up=1, 4 edges -> Gray 0x0001, 0x0003, 0x0002, 0x0006; Binary 0x0001..0x0004.
// 2. Load Gray 0x1234 (Enable=1 on the same edge) -> Gray 0x1234, Binary 0x1C27; no count step on that edge.
// 3. Load Gray 0x8000, Up=1 -> Binary 0xFFFF and Terminal_Count=1 before the next edge; that edge -> Gray 0x0000, Binary 0x0000.
// 4. From 0, Up=0, Enable=1 -> Terminal_Count=1; one edge -> Gray 0x8000, Binary 0xFFFF; the next edge -> Gray 0x8001, Binary 0xFFFE.
// 5. Enable=0 for 5 edges with Up toggling -> outputs hold; assert Reset_In mid-cycle (between edges) -> outputs 0 before the next edge.
// 6. 2000 edges of random Enable/Up with Load=0 -> every change has popcount(Gray_prev ^ Gray_now) == 1, and gray2bin(Gray) == Binary on every cycle.

Source files
------------

// File: rtl/gray_code_counter.sv
// rtl/gray_code_counter.sv - registered up/down counter with Gray and binary views
// One binary state register; the Gray register is updated from the same next-state value.
module gray_code_counter #(
  parameter int WIDTH = 16
) (
  input  logic             Clock_In,
  input  logic             Reset_In,
  input  logic             Enable_In,
  input  logic             Up_Down_In,
  input  logic             Load_In,
  input  logic [WIDTH-1:0] Load_Gray_Data_In,
  output logic [WIDTH-1:0] Gray_Count_Out,
  output logic [WIDTH-1:0] Binary_Count_Out,
  output logic             Terminal_Count_Out
);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] load_bin;

  // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
  always_comb begin
    load_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      load_bin[i] = ^(Load_Gray_Data_In >> i);
    end
  end

  always_comb begin
    bin_d  = bin_q;
    gray_d = gray_q;
    if (Load_In) begin
      bin_d  = load_bin;
      gray_d = Load_Gray_Data_In;
    end else if (Enable_In) begin
      if (Up_Down_In) begin
        bin_d = bin_q + 1'b1;
      end else begin
        bin_d = bin_q - 1'b1;
      end
      gray_d = bin_d ^ (bin_d >> 1);
    end
  end

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  assign Binary_Count_Out   = bin_q;
  assign Gray_Count_Out     = gray_q;
  assign Terminal_Count_Out = Enable_In & ~Load_In &
                              ((Up_Down_In & (&bin_q)) | (~Up_Down_In & ~(|bin_q)));

endmodule

// File: tb/tb_gray_code_counter.sv
// tb/tb_gray_code_counter.sv - directed self-checking bench for gray_code_counter
// Expected values are hand-computed constants plus a small binary reference count.
module tb_gray_code_counter;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_gray;
  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] bin;
  logic             tc;

  int n_cmp = 0;
  int n_bad = 0;

  gray_code_counter #(.WIDTH(WIDTH)) dut (
    .Clock_In          (clk),
    .Reset_In          (rst),
    .Enable_In         (en),
    .Up_Down_In        (up),
    .Load_In           (load),
    .Load_Gray_Data_In (load_gray),
    .Gray_Count_Out    (gray),
    .Binary_Count_Out  (bin),
    .Terminal_Count_Out(tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = g[i] ^ b[i+1];
    return b;
  endfunction

  logic [15:0] exp_gray [4] = '{16'h0001, 16'h0003, 16'h0002, 16'h0006};
  logic [WIDTH-1:0] model;
  logic [WIDTH-1:0] gray_prev;
  logic             r_en;
  logic             r_up;

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_gray = '0;
    #12;
    check("reset_gray", 32'(gray), 32'h0);
    check("reset_bin", 32'(bin), 32'h0);
    check("reset_tc", 32'(tc), 32'h0);

    // 1: count up four steps
    en = 1'b1; up = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("up_gray", 32'(gray), 32'(exp_gray[i]));
      check("up_bin", 32'(bin), 32'(i + 1));
    end

    // 2: load overrides enable
    load = 1'b1; load_gray = 16'h1234;
    step();
    check("load_gray", 32'(gray), 32'h1234);
    check("load_bin", 32'(bin), 32'h1C27);

    // 3: load all-ones then wrap up
    load_gray = 16'h8000;
    step();
    load = 1'b0; up = 1'b1; en = 1'b1;
    #1;
    check("wrapup_pre_bin", 32'(bin), 32'hFFFF);
    check("wrapup_tc", 32'(tc), 32'h1);
    step();
    check("wrapup_gray", 32'(gray), 32'h0000);
    check("wrapup_bin", 32'(bin), 32'h0000);
    check("wrapup_tc_after", 32'(tc), 32'h0);

    // 4: wrap down from zero
    up = 1'b0;
    #1;
    check("wrapdn_tc", 32'(tc), 32'h1);
    step();
    check("wrapdn_gray", 32'(gray), 32'h8000);
    check("wrapdn_bin", 32'(bin), 32'hFFFF);
    check("wrapdn_tc_after", 32'(tc), 32'h0);
    step();
    check("down_gray", 32'(gray), 32'h8001);
    check("down_bin", 32'(bin), 32'hFFFE);

    // 5: hold with enable low, then asynchronous reset between edges
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      up = ~up;
      step();
      check("hold_gray", 32'(gray), 32'h8001);
      check("hold_bin", 32'(bin), 32'hFFFE);
      check("hold_tc", 32'(tc), 32'h0);
    end
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_gray", 32'(gray), 32'h0);
    check("async_rst_bin", 32'(bin), 32'h0);
    en = 1'b1; up = 1'b0;
    #1;
    check("rst_tc_down", 32'(tc), 32'h1);
    up = 1'b1;
    #1;
    check("rst_tc_up", 32'(tc), 32'h0);
    step();
    check("rst_held_bin", 32'(bin), 32'h0);
    rst = 1'b0;
    step();
    check("release_gray", 32'(gray), 32'h0001);
    check("release_bin", 32'(bin), 32'h0001);

    // 6: pseudo-random enable/direction against a reference binary count
    model = 16'h0001;
    for (int i = 0; i < 2000; i++) begin
      r_en = 1'($urandom_range(0, 3) != 0);
      r_up = 1'($urandom_range(0, 1));
      en = r_en; up = r_up;
      gray_prev = gray;
      #1;
      check("rand_tc", 32'(tc),
            32'(r_en & ((r_up & (model == 16'hFFFF)) | (~r_up & (model == 16'h0000)))));
      step();
      if (r_en) model = r_up ? model + 16'h1 : model - 16'h1;
      check("rand_bin", 32'(bin), 32'(model));
      check("rand_decode", 32'(g2b(gray)), 32'(bin));
      check("rand_onebit", 32'($countones(gray_prev ^ gray)), 32'(r_en ? 1 : 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
